load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit_pkg.sv | 41 ++++
 rtl/load_store_unit_if.sv | 37 +++
 rtl/load_store_unit_lane_align.sv | 43 ++++
 rtl/load_store_unit.sv | 135 +++++++++++++
 tb/tb_load_store_unit.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/load_store_unit_pkg.sv
// Shared encodings for the load/store unit: access sizes, response error codes, FSM states.
// Defining LSU_SUBWORD_EN makes byte/half accesses legal; otherwise only word accesses are.
package load_store_unit_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_ILL  = 2'b11
    } lsu_size_e;

    typedef enum logic [1:0] {
        ERR_OK       = 2'b00,
        ERR_MISALIGN = 2'b01,
        ERR_TIMEOUT  = 2'b10,
        ERR_ILLEGAL  = 2'b11
    } lsu_err_e;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_RESP  = 2'd2;

    // Illegal size outranks misalignment.
    function automatic lsu_err_e lsu_req_check(input logic [1:0] size, input logic [1:0] lane);
        lsu_err_e err;
        err = ERR_OK;
        if (size == SZ_ILL) begin
            err = ERR_ILLEGAL;
        end
`ifndef LSU_SUBWORD_EN
        else if (size != SZ_WORD) begin
            err = ERR_ILLEGAL;
        end
`endif
        else if ((size == SZ_HALF && lane[0]) || (size == SZ_WORD && lane != 2'b00)) begin
            err = ERR_MISALIGN;
        end
        return err;
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// CPU request/response and memory-port signals of the load/store unit.
// slave = the unit itself, master = CPU plus memory driving it.
interface load_store_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;

    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_err;

    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    modport slave (
        input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
        input  mem_ack, mem_rdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
        output mem_req, mem_we, mem_addr, mem_wdata, mem_be
    );

    modport master (
        output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
        output mem_ack, mem_rdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_be
    );
endinterface

// File: rtl/load_store_unit_lane_align.sv
// Little-endian lane steering: store replication/byte enables and load extraction/extension.
// Purely combinational; the caller decides whether an access size is legal.
module lsu_lane_align
    import load_store_unit_pkg::*;
(
    input  logic [1:0]  i_size,
    input  logic [1:0]  i_lane,
    input  logic        i_unsigned,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_rdata,
    output logic [31:0] o_wdata,
    output logic [3:0]  o_be,
    output logic [31:0] o_rdata
);
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_byte = i_rdata[{i_lane, 3'b000} +: 8];
    assign w_half = i_lane[1] ? i_rdata[31:16] : i_rdata[15:0];

    always_comb begin
        o_wdata = i_wdata;
        o_be    = 4'b1111;
        o_rdata = i_rdata;
        case (i_size)
            SZ_BYTE: begin
                o_wdata = {4{i_wdata[7:0]}};
                o_be    = 4'b0001 << i_lane;
                o_rdata = {{24{w_byte[7] & ~i_unsigned}}, w_byte};
            end
            SZ_HALF: begin
                o_wdata = {2{i_wdata[15:0]}};
                o_be    = i_lane[1] ? 4'b1100 : 4'b0011;
                o_rdata = {{16{w_half[15] & ~i_unsigned}}, w_half};
            end
            default: begin
                o_wdata = i_wdata;
                o_be    = 4'b1111;
                o_rdata = i_rdata;
            end
        endcase
    end
endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: accepts one CPU access, runs a single memory beat, returns a one-cycle response.
// Byte/half accesses exist only when LSU_SUBWORD_EN is defined (see load_store_unit_pkg).
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    load_store_unit_if.slave bus
);
    localparam logic [7:0] LP_CNT_TC = 8'(TIMEOUT - 1);

    logic [1:0]  r_state;
    logic [7:0]  r_cnt;
    logic [1:0]  r_size;
    logic [1:0]  r_lane;
    logic        r_unsigned;
    logic        r_mem_req;
    logic        r_mem_we;
    logic [31:0] r_mem_addr;
    logic [31:0] r_mem_wdata;
    logic [3:0]  r_mem_be;
    logic        r_rsp_valid;
    logic [31:0] r_rsp_rdata;
    logic [1:0]  r_rsp_err;

    logic        w_idle;
    lsu_err_e    w_req_err;
    logic [1:0]  w_al_size;
    logic [1:0]  w_al_lane;
    logic        w_al_unsigned;
    logic [31:0] w_al_wdata;
    logic [31:0] w_al_rdata;
    logic [3:0]  w_al_be;

    assign w_idle    = (r_state == ST_IDLE);
    assign w_req_err = lsu_req_check(bus.req_size, bus.req_addr[1:0]);

    // One aligner serves both phases: store steering from the live request while idle,
    // load extraction from the captured request while the access is outstanding.
    assign w_al_size     = w_idle ? bus.req_size         : r_size;
    assign w_al_lane     = w_idle ? bus.req_addr[1:0]    : r_lane;
    assign w_al_unsigned = w_idle ? bus.req_unsigned     : r_unsigned;

    lsu_lane_align u_lane_align (
        .i_size     (w_al_size),
        .i_lane     (w_al_lane),
        .i_unsigned (w_al_unsigned),
        .i_wdata    (bus.req_wdata),
        .i_rdata    (bus.mem_rdata),
        .o_wdata    (w_al_wdata),
        .o_be       (w_al_be),
        .o_rdata    (w_al_rdata)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_size      <= '0;
            r_lane      <= '0;
            r_unsigned  <= 1'b0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_be    <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= ERR_OK;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.req_valid) begin
                        r_size     <= bus.req_size;
                        r_lane     <= bus.req_addr[1:0];
                        r_unsigned <= bus.req_unsigned;
                        if (w_req_err == ERR_OK) begin
                            r_state     <= ST_ISSUE;
                            r_cnt       <= '0;
                            r_mem_req   <= 1'b1;
                            r_mem_we    <= bus.req_write;
                            r_mem_addr  <= {bus.req_addr[31:2], 2'b00};
                            r_mem_wdata <= w_al_wdata;
                            r_mem_be    <= w_al_be;
                        end else begin
                            r_state     <= ST_RESP;
                            r_rsp_valid <= 1'b1;
                            r_rsp_err   <= w_req_err;
                            r_rsp_rdata <= '0;
                        end
                    end
                end
                ST_ISSUE: begin
                    // Ack is tested first so an ack on the terminal-count edge still completes.
                    if (bus.mem_ack) begin
                        r_state     <= ST_RESP;
                        r_mem_req   <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_rsp_err   <= ERR_OK;
                        r_rsp_rdata <= r_mem_we ? 32'd0 : w_al_rdata;
                    end else if (r_cnt == LP_CNT_TC) begin
                        r_state     <= ST_RESP;
                        r_mem_req   <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_rsp_err   <= ERR_TIMEOUT;
                        r_rsp_rdata <= '0;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                ST_RESP: begin
                    r_state     <= ST_IDLE;
                    r_rsp_valid <= 1'b0;
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_mem_req   <= 1'b0;
                    r_rsp_valid <= 1'b0;
                end
            endcase
        end
    end

    assign bus.req_ready = w_idle;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_rdata = r_rsp_rdata;
    assign bus.rsp_err   = r_rsp_err;
    assign bus.mem_req   = r_mem_req;
    assign bus.mem_we    = r_mem_we;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;
    assign bus.mem_be    = r_mem_be;
endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed cases plus randomized accesses against a
// transaction-level model; honours LSU_SUBWORD_EN the same way the design does.
module tb_load_store_unit;
    localparam int TMO = 4;

    logic clk;
    logic rst_n;
    load_store_unit_if bus();

    load_store_unit #(.TIMEOUT(TMO)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic logic [1:0] m_err(input logic [1:0] sz, input logic [31:0] a);
        if (sz == 2'd3) return 2'd3;
`ifndef LSU_SUBWORD_EN
        if (sz != 2'd2) return 2'd3;
`endif
        if ((a % (32'd1 << sz)) != 0) return 2'd1;
        return 2'd0;
    endfunction

    function automatic logic [3:0] m_be(input logic [1:0] sz, input logic [31:0] a);
        int n;
        n = 1 << sz;
        return 4'(((1 << n) - 1) << (a % 4));
    endfunction

    function automatic logic [31:0] m_wdata(input logic [1:0] sz, input logic [31:0] wd);
        logic [31:0] r;
        int n;
        n = 1 << sz;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % n) +: 8];
        return r;
    endfunction

    function automatic logic [31:0] m_load(input logic [1:0] sz, input logic u,
                                           input logic [31:0] a, input logic [31:0] rd);
        longint v;
        int n;
        n = 1 << sz;
        v = (longint'(rd) >> (8 * (a % 4))) & ((64'd1 << (8 * n)) - 1);
        if (!u && n < 4 && ((v >> (8 * n - 1)) & 1) == 1) v = v - (64'sd1 << (8 * n));
        return 32'(v);
    endfunction

    // ---------------- per-cycle expectations and compare process ----------------
    bit          chk_en = 0;
    logic        exp_ready = 1, exp_mreq = 0, exp_rv = 0, exp_we = 0;
    logic [31:0] exp_addr = 0, exp_wd = 0, exp_rdata = 0;
    logic [3:0]  exp_be = 0;
    logic [1:0]  exp_err = 0;

    always @(negedge clk) begin
        if (chk_en) begin
            check("req_ready", 32'(bus.req_ready), 32'(exp_ready));
            check("mem_req",   32'(bus.mem_req),   32'(exp_mreq));
            check("rsp_valid", 32'(bus.rsp_valid), 32'(exp_rv));
            if (exp_mreq) begin
                check("mem_we",    32'(bus.mem_we), 32'(exp_we));
                check("mem_addr",  bus.mem_addr,    exp_addr);
                check("mem_be",    32'(bus.mem_be), 32'(exp_be));
                check("mem_wdata", bus.mem_wdata,   exp_wd);
            end
            if (exp_rv) begin
                check("rsp_err",   32'(bus.rsp_err), 32'(exp_err));
                check("rsp_rdata", bus.rsp_rdata,    exp_rdata);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic scramble_req();
        bus.req_valid    = 1'($urandom_range(0, 1));
        bus.req_write    = 1'($urandom_range(0, 1));
        bus.req_size     = 2'($urandom_range(0, 3));
        bus.req_unsigned = 1'($urandom_range(0, 1));
        bus.req_addr     = $urandom;
        bus.req_wdata    = $urandom;
    endtask

    // Called at posedge+1 of a cycle where the unit must be idle; returns likewise.
    // d = ISSUE cycle (1-based) in which mem_ack is driven high.
    task automatic do_txn(input logic w, input logic [1:0] sz, input logic u, input logic [31:0] a,
                          input logic [31:0] wd, input int d, input logic [31:0] rd);
        logic [1:0]  e;
        logic [31:0] r_exp;
        bit          acked;
        e = m_err(sz, a);
        r_exp = 0;
        acked = 0;
        bus.req_valid = 1; bus.req_write = w; bus.req_size = sz; bus.req_unsigned = u;
        bus.req_addr = a; bus.req_wdata = wd;
        bus.mem_ack = 1'($urandom_range(0, 1)); bus.mem_rdata = $urandom;
        exp_ready = 1; exp_mreq = 0; exp_rv = 0;
        @(posedge clk); #1;
        if (e == 2'd0) begin
            exp_ready = 0; exp_mreq = 1; exp_we = w;
            exp_addr = a & 32'hFFFF_FFFC; exp_be = m_be(sz, a); exp_wd = m_wdata(sz, wd);
            for (int i = 1; i <= TMO && !acked; i++) begin
                scramble_req();
                bus.mem_ack   = (i == d);
                bus.mem_rdata = (i == d) ? rd : $urandom;
                @(posedge clk); #1;
                acked = (i == d);
            end
            if (!acked) e = 2'd2;
            else if (!w) r_exp = m_load(sz, u, a, rd);
        end
        exp_mreq = 0; exp_ready = 0; exp_rv = 1; exp_err = e; exp_rdata = r_exp;
        scramble_req();
        bus.mem_ack = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
        exp_rv = 0; exp_ready = 1;
        bus.req_valid = 0;
        bus.mem_ack = 1'($urandom_range(0, 1));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_ready"}, 32'(bus.req_ready), 32'd1);
        check({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
        check({tag, "_rsp_rdata"}, bus.rsp_rdata,      32'd0);
        check({tag, "_rsp_err"},   32'(bus.rsp_err),   32'd0);
        check({tag, "_mem_req"},   32'(bus.mem_req),   32'd0);
        check({tag, "_mem_we"},    32'(bus.mem_we),    32'd0);
        check({tag, "_mem_be"},    32'(bus.mem_be),    32'd0);
        check({tag, "_mem_addr"},  bus.mem_addr,       32'd0);
        check({tag, "_mem_wdata"}, bus.mem_wdata,      32'd0);
    endtask

    initial begin
        bus.req_valid = 0; bus.req_write = 0; bus.req_size = 0; bus.req_unsigned = 0;
        bus.req_addr = 0; bus.req_wdata = 0; bus.mem_ack = 0; bus.mem_rdata = 0;
        rst_n = 1;
        #1 rst_n = 0;
        #1 check_reset_outputs("por");

        // Model pins from hand-computed values.
        check("pin_lb",   m_load(2'd0, 1'b0, 32'h13, 32'h80FF_0000), 32'hFFFF_FF80);
        check("pin_lbu",  m_load(2'd0, 1'b1, 32'h13, 32'h80FF_0000), 32'h0000_0080);
        check("pin_lw",   m_load(2'd2, 1'b0, 32'h10, 32'h1234_5678), 32'h1234_5678);
        check("pin_sh_be", 32'(m_be(2'd1, 32'h22)),                  32'hC);
        check("pin_sh_wd", m_wdata(2'd1, 32'h0000_BEEF),             32'hBEEF_BEEF);
        check("pin_sb_be", 32'(m_be(2'd0, 32'h13)),                  32'h8);
        check("pin_mis",   32'(m_err(2'd2, 32'h6)),                  32'd1);
        check("pin_ill",   32'(m_err(2'd3, 32'h7)),                  32'd3);

        repeat (2) @(posedge clk);
        #2 rst_n = 1;
        @(posedge clk); #1;
        chk_en = 1;

        // Directed cases.
        do_txn(1'b0, 2'd2, 1'b0, 32'h0000_0010, 32'h0,         1,  32'h1234_5678);
        check("lw_rdata_latched", bus.rsp_rdata, 32'h1234_5678);
        do_txn(1'b0, 2'd0, 1'b0, 32'h0000_0013, 32'h0,         1,  32'h80FF_0000);
        do_txn(1'b0, 2'd0, 1'b1, 32'h0000_0013, 32'h0,         1,  32'h80FF_0000);
        do_txn(1'b1, 2'd1, 1'b0, 32'h0000_0022, 32'h0000_BEEF, 2,  32'h0);
        do_txn(1'b0, 2'd2, 1'b0, 32'h0000_0006, 32'h0,         1,  32'h0);
        do_txn(1'b0, 2'd3, 1'b0, 32'h0000_0007, 32'h0,         1,  32'h0);
        do_txn(1'b0, 2'd2, 1'b0, 32'h0000_0040, 32'h0,         99, 32'h0);
        do_txn(1'b0, 2'd2, 1'b0, 32'h0000_0044, 32'h0,         TMO, 32'hCAFE_F00D);
        do_txn(1'b0, 2'd1, 1'b0, 32'h0000_0102, 32'h0,         1,  32'h8001_7FFF);

        // Randomized accesses with random idle gaps.
        for (int t = 0; t < 300; t++) begin
            logic [1:0]  sz;
            logic [31:0] a;
            sz = 2'($urandom_range(0, 3));
            a = $urandom;
            if (sz != 2'd3 && $urandom_range(0, 3) != 0) a = a & ~((32'd1 << sz) - 1);
            do_txn(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom,
                   $urandom_range(1, TMO + 2), $urandom);
            repeat ($urandom_range(0, 2)) begin
                bus.mem_ack = 1'($urandom_range(0, 1));
                @(posedge clk); #1;
            end
        end

        // Reset in the middle of an outstanding access, then a late ack.
        chk_en = 0;
        bus.mem_ack = 0;
        bus.req_valid = 1; bus.req_write = 0; bus.req_size = 2'd2; bus.req_addr = 32'h0000_0080;
        @(posedge clk); #1;
        bus.req_valid = 0;
        check("rst_pre_mem_req", 32'(bus.mem_req), 32'd1);
        @(posedge clk); #1;
        #2 rst_n = 0;
        #1 check_reset_outputs("mid");
        @(posedge clk); #1;
        rst_n = 1;
        bus.mem_ack = 1;
        bus.mem_rdata = 32'hDEAD_BEEF;
        repeat (3) begin
            @(negedge clk);
            check("late_ack_rsp_valid", 32'(bus.rsp_valid), 32'd0);
            check("late_ack_mem_req",   32'(bus.mem_req),   32'd0);
            check("late_ack_req_ready", 32'(bus.req_ready), 32'd1);
        end
        bus.mem_ack = 0;
        @(posedge clk); #1;
        exp_ready = 1; exp_mreq = 0; exp_rv = 0;
        chk_en = 1;
        do_txn(1'b0, 2'd2, 1'b0, 32'h0000_0010, 32'h0, 1, 32'h0BAD_F00D);
        chk_en = 0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
